wptr_full_af: RTL
=================

WPTR_FULL_AF -- requirements
Module: wptr_full_af

Interface
REQ-001 SHALL have parameter ADDRSIZE, default 4: address width; DEPTH = 2^ADDRSIZE; legal range 2..12.
REQ-002 SHALL have parameter AF_DEFAULT, default 2^ADDRSIZE-2: reset value of the almost-full threshold register.
REQ-003 SHALL have port wclk  input  1  write-domain clock; the block uses one clock only and all state updates on its rising edge.
REQ-004 SHALL have port wrst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port winc  input  1  write request.
REQ-006 SHALL have port wq2_rptr  input  ADDRSIZE+1  read pointer, Gray code, already synchronised into wclk.
REQ-007 SHALL have port afull_thresh  input  ADDRSIZE+1  almost-full threshold value.
REQ-008 SHALL have port afull_ld  input  1  loads afull_thresh into the threshold register.
REQ-009 SHALL have port wovf_clr  input  1  clears the sticky overflow flag.
REQ-010 SHALL have port waddr  output  ADDRSIZE  RAM write address = wbin[ADDRSIZE-1:0].
REQ-011 SHALL have port wptr  output  ADDRSIZE+1  registered Gray write pointer.
REQ-012 SHALL have port wfull  output  1  registered full flag.
REQ-013 SHALL have port walmost_full  output  1  registered almost-full flag.
REQ-014 SHALL have port wlevel  output  ADDRSIZE+1  registered occupancy, 0..DEPTH.
REQ-015 SHALL have port woverflow  output  1  sticky flag for a write attempted while full.
REQ-016 SHALL have port wdrop  output  1  one-cycle pulse, one cycle after each write dropped while full.

Function
REQ-017 SHALL accept a write when winc=1 and wfull=0: wbinnext = wbin + accept, computed modulo 2^(ADDRSIZE+1).
REQ-018 SHALL register wptr <= wbinnext ^ (wbinnext>>1) on the same edge as wbin <= wbinnext, so the two never disagree.
REQ-019 SHALL convert wq2_rptr from Gray to binary rbin_s combinationally, with bit i = XOR of bits ADDRSIZE down to i.
REQ-020 SHALL compute level_next = (wbinnext - rbin_s) modulo 2^(ADDRSIZE+1).
REQ-021 SHALL register wlevel <= level_next, so wlevel reflects the write accepted on that edge.
REQ-022 SHALL register wfull <= (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
REQ-023 SHALL keep the REQ-022 condition equivalent to level_next == DEPTH; the verifier checks both.
REQ-024 SHALL deassert wfull one edge after wq2_rptr advances while full, with no write accepted during that cycle.
REQ-025 SHALL load thr <= afull_thresh on the edge where afull_ld=1; the load takes effect for the flag computed on the following edge.
REQ-026 SHALL register walmost_full <= (thr != 0) && (level_next >= thr); thr = 0 disables the flag.
REQ-027 SHALL saturate thr > DEPTH to DEPTH on load.
REQ-028 SHALL treat a write with winc=1 and wfull=1 as dropped: wbin and wptr unchanged, wdrop <= 1 for one cycle, woverflow <= 1.
REQ-029 SHALL clear woverflow on wovf_clr=1; when a drop and wovf_clr=1 occur in the same cycle, set wins.
REQ-030 SHALL wrap wbin from 2^(ADDRSIZE+1)-1 to 0 with no flag glitch; the full/level arithmetic stays correct across the wrap.
REQ-031 SHALL treat wq2_rptr values implying level > DEPTH (protocol violation) as follows: wfull=0, wlevel = the raw modulo value, and no assertion inside the block.

Reset
REQ-032 SHALL, with wrst=1 on a rising edge, set wbin=0, wptr=0, wfull=0, walmost_full=0, wlevel=0, woverflow=0, wdrop=0 and thr=AF_DEFAULT, regardless of every other input.
REQ-033 SHALL let wrst asserted mid-burst discard pending state, accepting no write on that edge.
REQ-034 SHALL accept the first write on the first edge after wrst is released.

Verification (ADDRSIZE=4, DEPTH=16, AF_DEFAULT=14)
REQ-035 SHALL cover: wrst=1 for 2 cycles with winc=1 and wq2_rptr=0 -> all outputs 0; after release, one winc gives wptr=00001, waddr=1, wlevel=1.
REQ-036 SHALL cover: 16 consecutive winc with wq2_rptr=0 -> after the 16th edge wfull=1, wlevel=16, wptr=11000, waddr=0, walmost_full=1 since the 14th edge.
REQ-037 SHALL cover: while full, winc=1 for 3 cycles -> wptr stays 11000, wdrop pulses 3 times, woverflow=1 until wovf_clr, then 0 the next edge.
REQ-038 SHALL cover: afull_ld with afull_thresh=8 then 8 writes -> walmost_full=1 after the 8th edge and 0 after the 7th; afull_thresh=0 -> walmost_full stays 0.
REQ-039 SHALL cover: full state, wq2_rptr changes to 00001 with winc=0 -> next edge wfull=0, wlevel=15; winc plus the same wq2_rptr -> wfull=1 again.
REQ-040 SHALL cover: 40 writes with wq2_rptr tracking wptr delayed 2 cycles -> wbin wraps past 31 to 0, wfull never 1, wlevel <= 3, wptr changes exactly 1 bit per accepted write.

Source files
------------

// File: rtl/wptr_full_af.sv
// Write-side pointer and flag logic for an asynchronous FIFO: binary/Gray write pointer,
// registered full, almost-full with a loadable threshold, occupancy level, and overflow
// reporting for writes dropped while full.
module wptr_full_af #(
  parameter int unsigned ADDRSIZE   = 4,
  parameter int unsigned AF_DEFAULT = (1 << ADDRSIZE) - 2
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic [ADDRSIZE:0]   afull_thresh,
  input  logic                afull_ld,
  input  logic                wovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow,
  output logic                wdrop
);

  localparam int unsigned W      = ADDRSIZE + 1;
  localparam int unsigned DEPTH  = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] DepthW = W'(DEPTH);
  // Out-of-range defaults saturate exactly like a runtime load would.
  localparam logic [ADDRSIZE:0] ThrRst = (AF_DEFAULT > DEPTH) ? DepthW : W'(AF_DEFAULT);

  logic [ADDRSIZE:0] wbin_q, wbin_d;
  logic [ADDRSIZE:0] wptr_q, wptr_d;
  logic [ADDRSIZE:0] wlevel_q, wlevel_d;
  logic [ADDRSIZE:0] thr_q, thr_d;
  logic              wfull_q, wfull_d;
  logic              walmost_full_q, walmost_full_d;
  logic              woverflow_q, woverflow_d;
  logic              wdrop_q, wdrop_d;

  logic              accept;
  logic              drop;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] level_next;
  logic [ADDRSIZE:0] full_cmp;

  // Next-state: pointer advance, Gray->binary read pointer, level and flag evaluation.
  always_comb begin
    accept     = winc & ~wfull_q;
    drop       = winc & wfull_q;
    wbin_d     = wbin_q + W'(accept);
    wgraynext  = wbin_d ^ (wbin_d >> 1);
    wptr_d     = wgraynext;

    rbin_s = '0;
    for (int i = 0; i < W; i++) begin
      rbin_s[i] = ^(wq2_rptr >> i);
    end

    level_next = wbin_d - rbin_s;
    wlevel_d   = level_next;

    // Full when the next write pointer is one lap ahead of the read pointer (Gray form).
    full_cmp = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    wfull_d  = (wgraynext == full_cmp);

    // Flag uses the threshold already in the register; a load lands one edge later.
    walmost_full_d = (thr_q != '0) && (level_next >= thr_q);

    thr_d = thr_q;
    if (afull_ld) begin
      thr_d = (afull_thresh > DepthW) ? DepthW : afull_thresh;
    end

    // A drop in the same cycle as a clear keeps the flag set.
    woverflow_d = woverflow_q;
    if (wovf_clr) woverflow_d = 1'b0;
    if (drop)     woverflow_d = 1'b1;

    wdrop_d = drop;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q         <= '0;
      wptr_q         <= '0;
      wlevel_q       <= '0;
      thr_q          <= ThrRst;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      woverflow_q    <= 1'b0;
      wdrop_q        <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wptr_q         <= wptr_d;
      wlevel_q       <= wlevel_d;
      thr_q          <= thr_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      woverflow_q    <= woverflow_d;
      wdrop_q        <= wdrop_d;
    end
  end

  assign waddr        = wbin_q[ADDRSIZE-1:0];
  assign wptr         = wptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wlevel       = wlevel_q;
  assign woverflow    = woverflow_q;
  assign wdrop        = wdrop_q;

endmodule
